// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer.
// Holds the FSM state encoding, the jump-unit path codes and the default reset PC.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWaitJu,
    StFault
  } seq_state_e;

  // Path index reported to the jump unit
  localparam logic [3:0] PathJ  = 4'd6;
  localparam logic [3:0] PathJr = 4'd7;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC arithmetic for the PC sequencer.
// Ports:
//   pc        in  32  current PC
//   br_off    in  16  signed word offset of a taken branch
//   pc_inc    out 32  pc + 1 (wraps mod 2^32)
//   br_target out 32  pc + 1 + sign-extended br_off (mod 2^32)
module pc_next_calc (
  input  logic [31:0] pc,
  input  logic [15:0] br_off,
  output logic [31:0] pc_inc,
  output logic [31:0] br_target
);

  always_comb begin
    pc_inc    = pc + 32'd1;
    br_target = pc_inc + {{16{br_off[15]}}, br_off};
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the PC sequentially, applies taken branches
// locally and hands J/JR jumps to an external jump unit, waiting for its result.
// Optional feature: define PC_SEQ_TIMEOUT_EN to fault after JU_TIMEOUT cycles in
// WAIT_JU without jump_done; otherwise WAIT_JU waits forever and fault is 0.
// Ports:
//   clk, rst (sync, active-high)      clock and reset
//   en, stall                         run enable, hold this cycle
//   br_req, br_taken, br_off          resolved branch and its signed word offset
//   j_req, j_addr / jr_req, jr_addr   J-type and register jump requests
//   ju_en, ju_jump, ju_path, ju_pc,
//   ju_addr, ju_reg                   latched request to the jump unit
//   jump_done, ju_pc_out              jump-unit completion and target
//   pc, pc_valid, redirect, busy,
//   fault                             sequencer status
// All outputs are registered.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = ResetPcDefault,
  parameter int unsigned JU_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        br_req,
  input  logic        br_taken,
  input  logic [15:0] br_off,
  input  logic        j_req,
  input  logic [25:0] j_addr,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  output logic        ju_en,
  output logic        ju_jump,
  output logic [3:0]  ju_path,
  output logic [31:0] ju_pc,
  output logic [25:0] ju_addr,
  output logic [31:0] ju_reg,
  input  logic        jump_done,
  input  logic [31:0] ju_pc_out,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic        busy,
  output logic        fault
);

  seq_state_e  state;
  logic [31:0] pc_inc;
  logic [31:0] br_target;

  pc_next_calc u_pc_next_calc (
    .pc        (pc),
    .br_off    (br_off),
    .pc_inc    (pc_inc),
    .br_target (br_target)
  );

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(JU_TIMEOUT + 1);
  logic [CntW-1:0] tmo_cnt;
  logic            fault_q;
  assign fault = fault_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^JU_TIMEOUT;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      redirect <= 1'b0;
      busy     <= 1'b0;
      ju_en    <= 1'b0;
      ju_jump  <= 1'b0;
      ju_path  <= 4'd0;
      ju_pc    <= 32'd0;
      ju_addr  <= 26'd0;
      ju_reg   <= 32'd0;
`ifdef PC_SEQ_TIMEOUT_EN
      tmo_cnt  <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          pc_valid <= 1'b0;
          redirect <= 1'b0;
          if (en) state <= StRun;
        end
        StRun: begin
          // pc_valid/redirect describe the step just taken, so a stalled,
          // disabled or jumping cycle clears them
          if (stall || !en) begin
            pc_valid <= 1'b0;
            redirect <= 1'b0;
            if (!stall) state <= StIdle;
          end else if (jr_req || j_req) begin
            state    <= StWaitJu;
            pc_valid <= 1'b0;
            redirect <= 1'b0;
            busy     <= 1'b1;
            ju_en    <= 1'b1;
            ju_jump  <= 1'b1;
            ju_path  <= jr_req ? PathJr : PathJ;
            ju_pc    <= pc_inc;
            ju_addr  <= j_addr;
            ju_reg   <= jr_addr;
          end else begin
            pc_valid <= 1'b1;
            redirect <= br_req && br_taken;
            pc       <= (br_req && br_taken) ? br_target : pc_inc;
          end
        end
        StWaitJu: begin
          if (jump_done) begin
            state    <= en ? StRun : StIdle;
            pc       <= ju_pc_out;
            redirect <= 1'b1;
            busy     <= 1'b0;
            ju_en    <= 1'b0;
            ju_jump  <= 1'b0;
`ifdef PC_SEQ_TIMEOUT_EN
            tmo_cnt  <= '0;
          end else if (tmo_cnt == CntW'(JU_TIMEOUT - 1)) begin
            state    <= StFault;
            fault_q  <= 1'b1;
            busy     <= 1'b0;
            ju_en    <= 1'b0;
            ju_jump  <= 1'b0;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt  <= tmo_cnt + CntW'(1);
`endif
          end
        end
        StFault: begin
          // Absorbing until rst
          pc_valid <= 1'b0;
          redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule
